// File: rtl/tb_uart_tx.sv
// Bench-side 8-N-1 UART transmitter with a byte FIFO feeding io_uart_rx.
// Optional even parity bit when TB_UART_TX_PARITY_EN is defined.
module tb_uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef TB_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, full, empty;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg;
  logic          shift, tx_n;
`ifdef TB_UART_TX_PARITY_EN
  logic          par;
`endif

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign level    = count;
  // Gating with reset keeps pushes offered during reset out of the FIFO.
  assign push     = in_valid && in_ready && reset;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      tx    <= tx_n;
    end
  end

  // Shift register and parity are payload only; they are always reloaded on pop.
  always_ff @(posedge clock) begin
    if (pop) begin
      shreg <= mem[rd_ptr];
`ifdef TB_UART_TX_PARITY_EN
      par   <= ^mem[rd_ptr];
`endif
    end else if (shift) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    pop     = 1'b0;
    shift   = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
          cnt_n   = CNT_MAX;
          idx_n   = '0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (cnt == '0) begin
          state_n = DATA;
          cnt_n   = CNT_MAX;
          idx_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (cnt == '0) begin
          shift = 1'b1;
          cnt_n = CNT_MAX;
          if (idx == 3'd7) begin
            idx_n = '0;
`ifdef TB_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
`ifdef TB_UART_TX_PARITY_EN
      PARITY: begin
        tx_n = par;
        if (cnt == '0) begin
          state_n = STOP;
          cnt_n   = CNT_MAX;
          idx_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (cnt == '0) begin
          cnt_n = CNT_MAX;
          if (idx == STOP_LAST) begin
            idx_n = '0;
            // Chain straight into the next start bit when a byte is waiting.
            if (!empty) begin
              pop     = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
              cnt_n   = '0;
            end
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tb_uart_tx.sv
// Self-checking bench for tb_uart_tx: a frame-level model predicts tx, level, busy and in_ready.
module tb_tb_uart_tx;
  localparam int CD    = 4;
  localparam int DEPTH = 8;
  localparam int STOP  = 1;
  localparam int CD2   = 2;
  localparam int STOP2 = 2;
`ifdef TB_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME  = (9 + PAR + STOP) * CD;
  localparam int FRAME2 = (9 + PAR + STOP2) * CD2;
  localparam int LOW2   = (9 + PAR) * CD2;

  logic       clock, reset;
  logic       in_valid, in_ready, tx, busy;
  logic [7:0] in_data;
  logic [3:0] level;
  logic       in_valid2, in_ready2, tx2, busy2;
  logic [7:0] in_data2;
  logic [3:0] level2;

  int checks, errors;

  // Reference model state
  bit         wave[$];
  logic [7:0] mq[$];
  int         rem;
  logic       exp_tx, exp_busy, exp_ready, acc;
  logic [3:0] exp_level;

  tb_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOP)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .level(level)
  );

  tb_uart_tx #(.CLK_DIV(CD2), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOP2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2), .level(level2)
  );

  always #5 clock = ~clock;

  // One clock edge: advance the model from the pre-edge inputs, then settle 1 time unit.
  task automatic tick();
    logic [7:0] b;
    logic do_push, do_pop;
    @(posedge clock);
    acc = 1'b0;
    if (!reset) begin
      mq.delete();
      wave.delete();
      rem    = 0;
      exp_tx = 1'b1;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = 1'b0;
      if (rem == 0) begin
        do_pop = (mq.size() != 0);
      end else begin
        rem--;
        if (rem == 0) do_pop = (mq.size() != 0);
      end
      exp_tx = (wave.size() != 0) ? wave.pop_front() : 1'b1;
      if (do_pop) begin
        b   = mq.pop_front();
        rem = FRAME;
        for (int k = 0; k < CD; k++) wave.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < CD; k++) wave.push_back(b[i]);
        if (PAR != 0)
          for (int k = 0; k < CD; k++) wave.push_back(^b);
        for (int k = 0; k < STOP * CD; k++) wave.push_back(1'b1);
      end
      if (do_push) mq.push_back(in_data);
      acc = do_push;
    end
    #1;
    exp_level = 4'(mq.size());
    exp_busy  = (rem != 0) || (mq.size() != 0);
    exp_ready = (mq.size() < DEPTH);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) tick();
    checks++;
    if ({tx, busy, in_ready, level} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: tx/busy/ready/level got %b/%b/%b/%0d want 1/0/1/0", tx, busy, in_ready, level);
    end
    checks++;
    if ({tx2, busy2, in_ready2, level2} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_state2: tx/busy/ready/level got %b/%b/%b/%0d want 1/0/1/0", tx2, busy2, in_ready2, level2);
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if (level !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_push_ignored: level/busy got %0d/%b want 0/0", level, busy);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= FRAME + 6; c++) begin
      tick();
      checks++;
      if ({tx, busy, in_ready, level} !== {exp_tx, exp_busy, exp_ready, exp_level}) begin
        errors++;
        $display("FAIL single c=%0d: tx/busy/ready/level got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, tx, busy, in_ready, level, exp_tx, exp_busy, exp_ready, exp_level);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (tx !== (c == 1)) begin
          errors++;
          $display("FAIL single_start_latency c=%0d: tx got %b want %b", c, tx, c == 1);
        end
      end
      if (c == FRAME || c == FRAME + 1) begin
        checks++;
        if (busy !== (c == FRAME)) begin
          errors++;
          $display("FAIL single_busy_fall c=%0d: busy got %b want %b", c, busy, c == FRAME);
        end
      end
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_data = a;
    tick();
    in_data = b;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 2 * FRAME + 6; c++) begin
      tick();
      checks++;
      if ({tx, busy, in_ready, level} !== {exp_tx, exp_busy, exp_ready, exp_level}) begin
        errors++;
        $display("FAIL back_to_back %h,%h c=%0d: tx/busy/ready/level got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 a, b, c, tx, busy, in_ready, level, exp_tx, exp_busy, exp_ready, exp_level);
      end
    end
  endtask

  task automatic test_stream();
    int  n, guard;
    logic saw_not_ready;
    n = 0; guard = 0; saw_not_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'($urandom);
    while (n < 20 && guard < 3000) begin
      tick();
      guard++;
      if (acc) begin
        n++;
        in_data = 8'($urandom);
        if (n == 20) in_valid = 1'b0;
      end
      if (in_ready === 1'b0) saw_not_ready = 1'b1;
      checks++;
      if ({tx, busy, in_ready, level} !== {exp_tx, exp_busy, exp_ready, exp_level}) begin
        errors++;
        $display("FAIL stream g=%0d: tx/busy/ready/level got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 guard, tx, busy, in_ready, level, exp_tx, exp_busy, exp_ready, exp_level);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL stream_accept_count: got %0d want 20", n);
    end
    checks++;
    if (saw_not_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_backpressure: in_ready low seen %b want 1", saw_not_ready);
    end
    for (int c = 0; c < 12 * FRAME; c++) begin
      tick();
      checks++;
      if ({tx, busy, in_ready, level} !== {exp_tx, exp_busy, exp_ready, exp_level}) begin
        errors++;
        $display("FAIL stream_drain c=%0d: tx/busy/ready/level got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, tx, busy, in_ready, level, exp_tx, exp_busy, exp_ready, exp_level);
      end
      if (!exp_busy && wave.size() == 0) break;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0;
    repeat (10) tick();
    checks++;
    if (level !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: level/busy got %0d/%b want 3/1", level, busy);
    end
    reset = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    tick();
    checks++;
    if ({tx, busy, in_ready, level} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_mid: tx/busy/ready/level got %b/%b/%b/%0d want 1/0/1/0", tx, busy, in_ready, level);
    end
    reset = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      checks++;
      if ({tx, busy, level} !== {1'b1, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL reset_residual c=%0d: tx/busy/level got %b/%b/%0d want 1/0/0", c, tx, busy, level);
      end
    end
  endtask

  task automatic test_stop2();
    in_valid2 = 1'b1; in_data2 = 8'h00;
    tick();
    in_valid2 = 1'b0;
    tick();
    checks++;
    if (tx2 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL stop2_pre: tx/busy got %b/%b want 1/1", tx2, busy2);
    end
    for (int c = 0; c < LOW2; c++) begin
      tick();
      checks++;
      if (tx2 !== 1'b0) begin
        errors++;
        $display("FAIL stop2_low c=%0d: tx got %b want 0", c, tx2);
      end
    end
    for (int c = 0; c < 2 * CD2; c++) begin
      tick();
      checks++;
      if (tx2 !== 1'b1 || busy2 !== (c != 2 * CD2 - 1)) begin
        errors++;
        $display("FAIL stop2_high c=%0d: tx/busy got %b/%b want 1/%b", c, tx2, busy2, c != 2 * CD2 - 1);
      end
    end
    checks++;
    if (FRAME2 != LOW2 + 2 * CD2 || level2 !== 4'd0) begin
      errors++;
      $display("FAIL stop2_end: level got %0d want 0", level2);
    end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    in_valid2 = 1'b0; in_data2 = 8'h00;
    checks = 0; errors = 0;
    rem = 0; exp_tx = 1'b1; acc = 1'b0;
    test_reset();
    test_single();
    test_back_to_back(8'hA5, 8'h3C);
    test_back_to_back(8'h07, 8'h03);
    test_stream();
    test_reset_mid();
    test_stop2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tb_uart_tx.md
# tb_uart_tx

Simulation-side UART transmitter that drives the harness `io_uart_rx` pin, the input the console receiver listens on. The bench pushes bytes through a valid/ready port into an internal FIFO. The block serialises each byte as an 8-N-1 frame (8 data bits, no parity, 1 stop bit by default) at a fixed clocks-per-bit rate. This lets directed tests inject console input into the SoC without an external tty. It sits beside `TestHarness` in the top-level bench and shares its `clock`.

## Interface
Parameters:
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥ 2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- `clock`  in  1  bench clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  byte offered on `in_data`.
- `in_data`  in  8  byte to transmit.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `tx`  out  1  serial line to `io_uart_rx`; idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: a byte is written to the FIFO on a rising edge where `in_valid && in_ready`. `in_data` may change freely when no transfer occurs.
- `in_ready` depends only on FIFO occupancy, never on `in_valid`. When the FIFO is full, a push is refused even if a pop happens in the same cycle. A push and a pop in the same cycle, with the FIFO not full, leave `level` unchanged.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE, or STOP → START directly when the FIFO is non-empty.
  - IDLE: `tx`=1. When the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLK_DIV` cycles.
  - DATA: 8 bits, LSB first, each held `CLK_DIV` cycles. A 3-bit bit index counts 0..7.
  - STOP: `tx`=1 for `STOP_BITS*CLK_DIV` cycles. At the last cycle, pop the next byte if one is available; otherwise return to IDLE.
- The baud counter counts down from `CLK_DIV-1`. A bit ends when the counter reaches 0; the counter reloads on every bit transition.
- `tx` comes straight from a flop, so it is glitch-free.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished using the extra occupancy bit.
- Reset (`reset`=0 at an edge): FIFO cleared and `level`=0; FSM goes to IDLE; `tx`=1; `busy`=0; `in_ready`=1; counters = 0.
  - A frame in flight is abandoned immediately. The partial frame's byte is lost.
  - Pushes offered during reset are ignored.

## Timing
- Acceptance into an empty FIFO while IDLE at edge E: the FSM pops at E+1, and `tx` falls at E+2.
- Frame length: (1 + 8 + STOP_BITS)·CLK_DIV cycles, plus CLK_DIV when parity is enabled.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop cycle, with no idle gap.
- `level` and `in_ready` update on the edge after a push or pop.
- `busy` rises one cycle after the first accepted push. It falls on the edge at which the FSM enters IDLE with the FIFO empty.

## Configuration
- `TB_UART_TX_PARITY_EN` defined:
  - An even-parity bit follows the data bits, held `CLK_DIV` cycles.
  - Parity bit = XOR of the 8 data bits.
  - The frame gains one bit time.
- Not defined: no PARITY state exists; the frame is 8-N-STOP_BITS.

## Test plan
- CLK_DIV=4, push 0x55 after reset → `tx` low for 4 cycles starting at E+2. Then the data bits are 1,0,1,0,1,0,1,0, each 4 cycles. Then high for 4 cycles. `busy` falls at the end; total frame 40 cycles.
- Push 0xA5 then 0x3C on consecutive cycles → two contiguous 40-cycle frames with no idle cycle between them. The decoded bytes are 0xA5, 0x3C in order.
- Hold `in_valid`=1 with FIFO_DEPTH=8 while transmitting:
  - `in_ready` drops once `level`=8; that is the 9th offered byte, since the 1st byte pops at E+1.
  - No byte is dropped or duplicated.
  - `level` wraps correctly across 20 bytes.
- Assert `reset`=0 mid-DATA of 0xFF with 3 bytes queued → next edge: `tx`=1, `level`=0, `busy`=0. After release, no residual frame appears.
- With `TB_UART_TX_PARITY_EN`, CLK_DIV=2:
  - Send 0x07 → the parity bit is 1.
  - Send 0x03 → the parity bit is 0.
  - Frame length is 22 cycles.
- STOP_BITS=2, CLK_DIV=2, push 0x00 → `tx` is low for 18 cycles (start bit plus 8 zero data bits), then high for 4 cycles.
